countdown_60: RTL
=================

Name: countdown_60

Overview:
- Loadable BCD modulo-60 down-counter / countdown timer: the decrementing counterpart of the mod-60 up-counter used in the clock datapath.
- Counts a BCD value from a loaded start (max 59) down to 00, one step per qualified `en` tick.
- At 00 it flags a borrow and signals completion.
- Sits beside the seconds/minutes counters for alarm and timer functions.

Parameters:
- PRESET, 8'h59, BCD value for `count` and the reload register after reset. Must be valid BCD, tens ≤5, units ≤9.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  tick enable; one decrement per cycle with en=1 while RUN.
- load  input  1  load `load_val` into `count` and the reload register.
- load_val  input  8  BCD load value {tens[7:4], units[3:0]}.
- start  input  1  IDLE/DONE -> RUN.
- stop  input  1  RUN -> IDLE; `count` holds.
- count  output  8  current BCD value {tens, units}.
- bo  output  1  borrow-out, combinational: RUN & en & count==8'h00.
- busy  output  1  1 while state==RUN.
- done  output  1  one-cycle pulse on the RUN->DONE transition.
- err  output  1  one-cycle pulse when a load is rejected as invalid BCD.

Behaviour:
- Reset (async, rst=1): count=PRESET, reload register=PRESET, state=IDLE, done=0, err=0, busy=0, bo=0. Reset mid-RUN aborts immediately, with no done pulse.
- States:
  - IDLE: count held; en ignored.
  - RUN: decrement on en.
  - DONE: count held at 00; en ignored.
- Per-edge priority: rst > load > stop > start > en-decrement.
- load:
  - Valid when load_val[7:4] ≤5 and load_val[3:0] ≤9.
  - Valid: count and reload register take load_val next edge; state unchanged, except DONE -> IDLE.
  - Invalid: nothing changes; err=1 for exactly the next cycle.
  - A load in the same cycle as en in RUN wins; no decrement that cycle.
- stop: in RUN -> IDLE next edge. Ignored in IDLE/DONE. Wins over a same-cycle start.
- start:
  - IDLE -> RUN.
  - DONE -> RUN, after first restoring count from the reload register on the same edge.
  - Ignored in RUN.
  - start in IDLE with count==00 enters RUN; the first en then completes.
- Decrement in RUN with en=1 (tens and units both BCD, never leaving 0..9 / 0..5):
  - units≠0: units-1.
  - units==0, tens≠0: units=9, tens-1.
  - count==00: bo=1 that cycle; terminal behaviour per Optional Feature.
- Terminal (no wrap): count stays 00, state -> DONE, done=1 for the following cycle only.
- Latency:
  - count updates one edge after the qualifying en.
  - busy reflects state (registered).
  - done and err are registered pulses.
- Worked example: 8'h59 -> 00 takes 59 en ticks; the 60th en produces bo and the terminal action.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - At the terminal event (count==00 & en in RUN), count reloads from the reload register and state stays RUN.
  - done still pulses one cycle per terminal event; bo behaves as without the macro.
  - Continuous periodic timer with period (reload value + 1) en ticks.
- Undefined: terminal behaviour as in Behaviour (RUN -> DONE, hold 00).

Test Plan:
- Reset then observe: count=8'h59, busy=0, done=0, bo=0. Assert rst mid-RUN at count=8'h37 -> count=8'h59 immediately (async), busy=0, no done pulse.
- load 8'h12, start, en held high -> count sequence 12,11,10,09,…,00.
  - bo=1 on the 13th en cycle.
  - done pulses once the following cycle; busy=0; count stays 00 under further en.
- load 8'h6A (invalid) -> err pulses 1 cycle, count unchanged. load 8'h5A (invalid units) -> err pulses. load 8'h50 -> count=8'h50, no err.
- RUN at 8'h40, en=1 with load 8'h25 same cycle -> count=8'h25 (no decrement). stop+start same cycle -> IDLE, count held; 5 en cycles in IDLE -> no change.
- From DONE after a load of 8'h03: start -> count restored to 8'h03, busy=1; 4 en ticks -> done pulse again.
- With COUNTDOWN_AUTO_RELOAD_EN: load 8'h02, start, en continuous -> 02,01,00,02,01,00…; done pulses every 3rd en; busy stays 1.

Source files
------------

// File: rtl/countdown_60_if.sv
// ============================================================================
// Module      : countdown_60_if
// Description : Control/status bundle of the BCD mod-60 countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface countdown_60_if;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       stop;
    logic [7:0] count;
    logic       bo;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output en, load, load_val, start, stop,
        input  count, bo, busy, done, err
    );

    modport slave (
        input  en, load, load_val, start, stop,
        output count, bo, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/countdown_60.sv
// ============================================================================
// Module      : countdown_60
// Description : Loadable BCD modulo-60 down-counter / countdown timer.
//               Optional macro COUNTDOWN_AUTO_RELOAD_EN turns it into a
//               periodic timer that reloads at 00 instead of stopping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_60 #(
    parameter logic [7:0] PRESET = 8'h59
) (
    input  logic          clk,
    input  logic          rst,
    countdown_60_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0] r_state;
    logic [7:0] r_count;
    logic [7:0] r_reload;
    logic       r_done;
    logic       r_err;

    logic       w_valid;
    logic       w_zero;
    logic       w_tick;

    assign w_valid = (bus.load_val[7:4] <= 4'd5) && (bus.load_val[3:0] <= 4'd9);
    assign w_zero  = (r_count == 8'h00);
    assign w_tick  = (r_state == c_RUN) && bus.en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_count  <= PRESET;
            r_reload <= PRESET;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (bus.load) begin
                if (w_valid) begin
                    r_count  <= bus.load_val;
                    r_reload <= bus.load_val;
                    if (r_state == c_DONE)
                        r_state <= c_IDLE;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (bus.stop) begin
                // An asserted stop also suppresses any same-cycle start.
                if (r_state == c_RUN)
                    r_state <= c_IDLE;
            end else if (bus.start && (r_state != c_RUN)) begin
                if (r_state == c_DONE)
                    r_count <= r_reload;
                r_state <= c_RUN;
            end else if (w_tick) begin
                if (w_zero) begin
                    r_done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    r_count <= r_reload;
`else
                    r_state <= c_DONE;
`endif
                end else if (r_count[3:0] != 4'd0) begin
                    r_count <= {r_count[7:4], r_count[3:0] - 4'd1};
                end else begin
                    r_count <= {r_count[7:4] - 4'd1, 4'd9};
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.bo    = w_tick && w_zero;
    assign bus.busy  = (r_state == c_RUN);
    assign bus.done  = r_done;
    assign bus.err   = r_err;

endmodule

`default_nettype wire
